// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Merges two register-file writeback requesters onto a single write port.
//   Requester A (ALU writeback) and requester B (load return) use a
//   valid/ready handshake. Ties are resolved round-robin, with A winning the
//   first tie after reset. An accepted write appears on wr_* one cycle later.
//   Writes to register 0 are dropped and counted in zero_drops.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   a_valid    : requester A presents a write
//   a_addr     : destination register of A
//   a_data     : write data of A
//   a_ready    : A's write is accepted this cycle (combinational)
//   b_valid    : requester B presents a write
//   b_addr     : destination register of B
//   b_data     : write data of B
//   b_ready    : B's write is accepted this cycle (combinational)
//   wr_stall   : register-file write port unavailable this cycle
//   wr_en      : registered write strobe to the register file
//   wr_addr    : registered write index
//   wr_data    : registered write data
//   zero_drops : saturating count of accepted writes to register 0
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_data,
  output logic              b_ready,
  input  logic              wr_stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic [7:0]        zero_drops
);

  // 1 when B won the most recent grant; resets to 1 so A takes the first tie.
  logic              last_b_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [WIDTH-1:0]  wr_data_r;
  logic [7:0]        zero_drops_r;

  logic              a_grant_s;
  logic              b_grant_s;
  logic              accept_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [WIDTH-1:0]  sel_data_s;

  // Grant decision: nothing is granted during reset or while the port stalls.
  always_comb begin
    a_grant_s = 1'b0;
    b_grant_s = 1'b0;
    if (rst_n && !wr_stall) begin
      if (a_valid && b_valid) begin
        if (last_b_r) begin
          a_grant_s = 1'b1;
        end else begin
          b_grant_s = 1'b1;
        end
      end else if (a_valid) begin
        a_grant_s = 1'b1;
      end else if (b_valid) begin
        b_grant_s = 1'b1;
      end else begin
        a_grant_s = 1'b0;
        b_grant_s = 1'b0;
      end
    end else begin
      a_grant_s = 1'b0;
      b_grant_s = 1'b0;
    end
  end

  // Select the winning requester's write.
  always_comb begin
    accept_s = a_grant_s | b_grant_s;
    if (b_grant_s) begin
      sel_addr_s = b_addr;
      sel_data_s = b_data;
    end else begin
      sel_addr_s = a_addr;
      sel_data_s = a_data;
    end
  end

  // Writeback register stage, round-robin state and register-0 drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_r     <= 1'b1;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= {ADDR_W{1'b0}};
      wr_data_r    <= {WIDTH{1'b0}};
      zero_drops_r <= 8'd0;
    end else if (accept_s) begin
      // Round-robin state advances even for dropped register-0 writes.
      last_b_r <= b_grant_s;
      if (sel_addr_s != {ADDR_W{1'b0}}) begin
        wr_en_r   <= 1'b1;
        wr_addr_r <= sel_addr_s;
        wr_data_r <= sel_data_s;
      end else begin
        wr_en_r <= 1'b0;
        if (zero_drops_r != 8'hFF) begin
          zero_drops_r <= zero_drops_r + 8'd1;
        end else begin
          zero_drops_r <= zero_drops_r;
        end
      end
    end else begin
      // No acceptance: strobe drops, address/data hold.
      wr_en_r <= 1'b0;
    end
  end

  assign a_ready    = a_grant_s;
  assign b_ready    = b_grant_s;
  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign zero_drops = zero_drops_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [WIDTH-1:0]  a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [WIDTH-1:0]  b_data;
  logic              b_ready;
  logic              wr_stall;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [7:0]        zero_drops;

  int errors;
  int checks;

  regfile_wb_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .wr_stall   (wr_stall),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .zero_drops (zero_drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ready pair observed vs expected {a_ready,b_ready}.
  task automatic chk_rdy(input string name, input logic [1:0] exp);
    checks++;
    if ({a_ready, b_ready} !== exp) begin
      errors++;
      $display("FAIL %s: ready{a,b} got=%b want=%b", name, {a_ready, b_ready}, exp);
    end
  endtask

  // Write port observed vs expected.
  task automatic chk_wr(input string name, input logic en, input logic [ADDR_W-1:0] ad,
                        input logic [WIDTH-1:0] da);
    checks++;
    if (wr_en !== en || wr_addr !== ad || wr_data !== da) begin
      errors++;
      $display("FAIL %s: wr got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h",
               name, wr_en, wr_addr, wr_data, en, ad, da);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr_stall = 1'b0;
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h2;
    #2;
    chk_rdy("reset_ready", 2'b00);
    chk_wr("reset_wr", 1'b0, 5'd0, 32'h0);
    checks++;
    if (zero_drops !== 8'd0) begin
      errors++;
      $display("FAIL reset_zd: got=%0d want=0", zero_drops);
    end
    @(posedge clk); #1;
    chk_wr("reset_hold_wr", 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_tie;
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h22;
    #1 chk_rdy("tie_c0", 2'b10);
    @(posedge clk); #1;
    chk_wr("tie_wr0", 1'b1, 5'd3, 32'h11);
    @(negedge clk);
    a_valid = 1'b0;
    #1 chk_rdy("tie_c1", 2'b01);
    @(posedge clk); #1;
    chk_wr("tie_wr1", 1'b1, 5'd3, 32'h22);
    @(negedge clk);
    b_valid = 1'b0;
    @(posedge clk); #1;
    chk_wr("tie_idle", 1'b0, 5'd3, 32'h22);
  endtask

  task automatic test_sustained;
    logic [WIDTH-1:0] exp_d;
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA0;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'hB0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i % 2 == 0) chk_rdy("sus_rdy", 2'b10);
      else            chk_rdy("sus_rdy", 2'b01);
      @(posedge clk); #1;
      if (i % 2 == 0) begin
        exp_d = 32'hA0 + 32'(i);
        chk_wr("sus_wr", 1'b1, 5'd1, exp_d);
      end else begin
        exp_d = 32'hB0 + 32'(i);
        chk_wr("sus_wr", 1'b1, 5'd2, exp_d);
      end
      @(negedge clk);
      // New data for the requester just accepted; the other holds.
      if (i % 2 == 0) b_data = 32'hB0 + 32'(i + 1);
      else            a_data = 32'hA0 + 32'(i + 1);
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_single;
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    #1 chk_rdy("single_rdy", 2'b10);
    @(posedge clk); #1;
    chk_wr("single_wr", 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    a_valid = 1'b0;
    @(posedge clk); #1;
    chk_wr("single_after", 1'b0, 5'd5, 32'hDEADBEEF);
  endtask

  task automatic test_stall;
    @(negedge clk);
    wr_stall = 1'b1;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
    b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h88;
    for (int i = 0; i < 3; i++) begin
      #1 chk_rdy("stall_rdy", 2'b00);
      @(posedge clk); #1;
      chk_wr("stall_wr", 1'b0, 5'd5, 32'hDEADBEEF);
      @(negedge clk);
    end
    wr_stall = 1'b0;
    #1 chk_rdy("stall_rel", 2'b01);
    @(posedge clk); #1;
    chk_wr("stall_rel_wr", 1'b1, 5'd8, 32'h88);
    @(negedge clk);
    b_valid = 1'b0;
    wr_stall = 1'b1;
    #1 chk_rdy("stall_again", 2'b00);
    chk_wr("stall_prev_wr", 1'b1, 5'd8, 32'h88);
    @(posedge clk); #1;
    chk_wr("stall_again_wr", 1'b0, 5'd8, 32'h88);
    @(negedge clk);
    wr_stall = 1'b0;
    #1 chk_rdy("stall_loser", 2'b10);
    @(posedge clk); #1;
    chk_wr("stall_loser_wr", 1'b1, 5'd7, 32'h77);
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic test_zero_drop;
    @(negedge clk);
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h12345678;
    for (int i = 0; i < 300; i++) begin
      #1 chk_rdy("zero_rdy", 2'b01);
      @(posedge clk); #1;
      chk_wr("zero_wr", 1'b0, 5'd7, 32'h77);
      if (i == 9) begin
        checks++;
        if (zero_drops !== 8'd10) begin
          errors++;
          $display("FAIL zero_cnt10: got=%0d want=10", zero_drops);
        end
      end
      @(negedge clk);
    end
    b_valid = 1'b0;
    checks++;
    if (zero_drops !== 8'd255) begin
      errors++;
      $display("FAIL zero_sat: got=%0d want=255", zero_drops);
    end
  endtask

  task automatic test_reset_mid;
    // Last grant was B (zero drops), so this lone A write leaves A as last winner.
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h44;
    @(posedge clk); #1;
    chk_wr("mid_acc", 1'b1, 5'd4, 32'h44);
    #2 rst_n = 1'b0;
    #1;
    chk_wr("mid_rst_wr", 1'b0, 5'd0, 32'h0);
    chk_rdy("mid_rst_rdy", 2'b00);
    checks++;
    if (zero_drops !== 8'd0) begin
      errors++;
      $display("FAIL mid_rst_zd: got=%0d want=0", zero_drops);
    end
    @(posedge clk); #1;
    chk_wr("mid_rst_discard", 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'hAA;
    #1 chk_rdy("mid_tie", 2'b10);
    @(posedge clk); #1;
    chk_wr("mid_tie_wr", 1'b1, 5'd9, 32'h99);
    @(negedge clk);
    a_valid = 1'b0;
    #1 chk_rdy("mid_tie_b", 2'b01);
    @(posedge clk); #1;
    chk_wr("mid_tie_b_wr", 1'b1, 5'd9, 32'hAA);
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_tie();
    test_sustained();
    test_single();
    test_stall();
    test_zero_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the register index width (32 registers).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port a_valid, input, 1 bit: requester A (ALU writeback) presents a write.
REQ-006 The block SHALL have port a_addr, input, ADDR_W bits: destination register of A.
REQ-007 The block SHALL have port a_data, input, WIDTH bits: write data of A.
REQ-008 The block SHALL have port a_ready, output, 1 bit: A's write is accepted this cycle.
REQ-009 The block SHALL have ports b_valid, b_addr, b_data and b_ready, with the same directions, widths and meanings as the A ports, for requester B (load return).
REQ-010 The block SHALL have port wr_stall, input, 1 bit: the register-file write port is unavailable this cycle.
REQ-011 The block SHALL have port wr_en, output, 1 bit: write strobe to the register file (qualifies the address decoder).
REQ-012 The block SHALL have port wr_addr, output, ADDR_W bits: registered write index.
REQ-013 The block SHALL have port wr_data, output, WIDTH bits: registered write data.
REQ-014 The block SHALL have port zero_drops, output, 8 bits: saturating count of accepted writes to register 0.

Function
REQ-015 Handshake: a write SHALL be accepted in a cycle when x_valid and x_ready are both 1; requesters hold valid, addr and data stable until accepted.
REQ-016 a_ready and b_ready SHALL be combinational, SHALL never both be 1 in the same cycle, and SHALL both be 0 while wr_stall=1.
REQ-017 If exactly one requester is valid and wr_stall=0, that requester SHALL receive ready in the same cycle.
REQ-018 If both requesters are valid and wr_stall=0, ready SHALL go to the requester that did not win the most recent grant (round-robin); after reset, A wins the first tie.
REQ-019 A 1-bit last_grant register SHALL update only on an accepted write, including writes to register 0.
REQ-020 An accepted write with addr!=0 SHALL drive wr_en=1, wr_addr=addr and wr_data=data in the following cycle only (latency 1).
REQ-021 An accepted write with addr=0 SHALL leave wr_en=0 in the following cycle and increment zero_drops by 1, saturating at 255.
REQ-022 In any cycle following a cycle with no accepted write, wr_en SHALL be 0, and wr_addr and wr_data SHALL hold their previous values.
REQ-023 If both requesters target the same register in the same cycle, the two writes SHALL reach wr_* in grant order on separate cycles, the loser's write last.
REQ-024 A requester that loses a tie SHALL be granted no later than the next cycle in which wr_stall=0.
REQ-025 wr_stall SHALL block only new acceptances; a write accepted in the previous cycle SHALL still appear on wr_* regardless of wr_stall.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately force wr_en=0, wr_addr=0, wr_data=0, zero_drops=0, and last_grant to the state in which A wins the next tie, regardless of clk.
REQ-027 A write accepted in the cycle in which reset asserts SHALL be discarded and SHALL NOT appear on wr_*.
REQ-028 While rst_n=0, a_ready and b_ready SHALL be 0.

Verification
REQ-029 Single write: a_valid=1, a_addr=5, a_data=0xDEADBEEF -> a_ready=1 in the same cycle; in the next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; wr_en=0 the cycle after.
REQ-030 Tie after reset: A (addr 3, 0x11) and B (addr 3, 0x22) both valid -> cycle 0 grants A and cycle 1 grants B; wr_* shows reg 3 = 0x11, then reg 3 = 0x22.
REQ-031 Sustained tie: both requesters valid for 6 cycles with new data each handshake -> grants alternate A,B,A,B,A,B with no idle cycle on wr_en.
REQ-032 Zero drop: b_valid=1, b_addr=0, repeated 300 times -> wr_en stays 0 and zero_drops ends at 255.
REQ-033 Stall: both valid with wr_stall=1 for 3 cycles -> no ready for 3 cycles; on release, the winner is the round-robin choice and the loser is granted the next cycle.
REQ-034 Reset mid-operation: rst_n is driven low asynchronously in the cycle after an accept -> wr_en falls to 0 immediately, zero_drops=0, and the first tie after reset release is won by A.
